// File: rtl/litedram_port_arbiter_pkg.sv
// Shared types and default sizing for the two-requester LiteDRAM port arbiter.
package litedram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2
  } arb_state_t;

  // Requester id: 0 = p0, 1 = p1
  typedef logic req_id_t;

  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 256;
  localparam int DEF_MAX_RD = 4;

endpackage

// File: rtl/litedram_port_arbiter_tag_fifo.sv
// Small FIFO of requester ids, one entry per outstanding read, so returning
// in-order read data can be steered back to the requester that issued it.
module litedram_tag_fifo
  import litedram_arb_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_RD
) (
  input  logic                     user_clk,
  input  logic                     user_rst_n,
  input  logic                     push,
  input  req_id_t                  push_id,
  input  logic                     pop,
  output req_id_t                  head_id,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  req_id_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = mem[rd_ptr];

  // Tag storage needs no reset: entries are only read while count is non-zero
  always_ff @(posedge user_clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/litedram_port_arbiter.sv
// Round-robin arbiter sharing one LiteDRAM native user port between two
// requesters. Commands are granted one at a time; write data follows its
// command; read data is routed back by the tag FIFO in issue order.
module litedram_port_arbiter
  import litedram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_RD = DEF_MAX_RD
) (
  input  logic                user_clk,
  input  logic                user_rst_n,
  input  logic                p0_cmd_valid,
  output logic                p0_cmd_ready,
  input  logic                p0_cmd_we,
  input  logic [ADDR_W-1:0]   p0_cmd_addr,
  input  logic                p0_wdata_valid,
  output logic                p0_wdata_ready,
  input  logic [DATA_W/8-1:0] p0_wdata_we,
  input  logic [DATA_W-1:0]   p0_wdata_data,
  output logic                p0_rdata_valid,
  input  logic                p0_rdata_ready,
  output logic [DATA_W-1:0]   p0_rdata_data,
  input  logic                p1_cmd_valid,
  output logic                p1_cmd_ready,
  input  logic                p1_cmd_we,
  input  logic [ADDR_W-1:0]   p1_cmd_addr,
  input  logic                p1_wdata_valid,
  output logic                p1_wdata_ready,
  input  logic [DATA_W/8-1:0] p1_wdata_we,
  input  logic [DATA_W-1:0]   p1_wdata_data,
  output logic                p1_rdata_valid,
  input  logic                p1_rdata_ready,
  output logic [DATA_W-1:0]   p1_rdata_data,
  output logic                m_cmd_valid,
  input  logic                m_cmd_ready,
  output logic                m_cmd_we,
  output logic [ADDR_W-1:0]   m_cmd_addr,
  output logic                m_wdata_valid,
  input  logic                m_wdata_ready,
  output logic [DATA_W/8-1:0] m_wdata_we,
  output logic [DATA_W-1:0]   m_wdata_data,
  input  logic                m_rdata_valid,
  output logic                m_rdata_ready,
  input  logic [DATA_W-1:0]   m_rdata_data,
  output logic                busy,
  output logic                rd_err
);

  arb_state_t               state;
  req_id_t                  grant;
  req_id_t                  prio;
  req_id_t                  pick;
  req_id_t                  head_id;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic [$clog2(MAX_RD):0]  rd_count;
  logic                     elig0;
  logic                     elig1;
  logic                     g_we;
  logic                     cmd_hs;
  logic                     wdata_hs;
  logic                     tag_push;
  logic                     rd_pop;

  // A read is only eligible while a tag slot is free; writes always are
  assign elig0    = p0_cmd_valid & (p0_cmd_we | ~fifo_full);
  assign elig1    = p1_cmd_valid & (p1_cmd_we | ~fifo_full);
  assign pick     = (elig0 & elig1) ? prio : elig1;
  assign g_we     = grant ? p1_cmd_we : p0_cmd_we;
  assign cmd_hs   = m_cmd_valid & m_cmd_ready;
  assign wdata_hs = m_wdata_valid & m_wdata_ready;
  assign tag_push = cmd_hs & ~g_we;
  assign rd_pop   = m_rdata_valid & m_rdata_ready;
  assign busy     = (state != IDLE) | (rd_count != '0);

  // Grant FSM: arbitrate in IDLE, then hold the grant until the command
  // (and its write beat, for writes) has been accepted
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state <= IDLE;
      grant <= 1'b0;
      prio  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (elig0 | elig1) begin
            grant <= pick;
            prio  <= ~pick;
            state <= CMD;
          end
        end
        CMD: begin
          if (m_cmd_ready) state <= g_we ? WDATA : IDLE;
        end
        WDATA: begin
          if (wdata_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Forward the granted requester's command/write fields; everything idle otherwise
  always_comb begin
    m_cmd_valid    = 1'b0;
    m_cmd_we       = 1'b0;
    m_cmd_addr     = '0;
    p0_cmd_ready   = 1'b0;
    p1_cmd_ready   = 1'b0;
    m_wdata_valid  = 1'b0;
    m_wdata_we     = '0;
    m_wdata_data   = '0;
    p0_wdata_ready = 1'b0;
    p1_wdata_ready = 1'b0;
    if (state == CMD) begin
      m_cmd_valid  = 1'b1;
      m_cmd_we     = g_we;
      m_cmd_addr   = grant ? p1_cmd_addr : p0_cmd_addr;
      p0_cmd_ready = ~grant & m_cmd_ready;
      p1_cmd_ready = grant & m_cmd_ready;
    end
    if (state == WDATA) begin
      m_wdata_valid  = grant ? p1_wdata_valid : p0_wdata_valid;
      m_wdata_we     = grant ? p1_wdata_we : p0_wdata_we;
      m_wdata_data   = grant ? p1_wdata_data : p0_wdata_data;
      p0_wdata_ready = ~grant & m_wdata_ready;
      p1_wdata_ready = grant & m_wdata_ready;
    end
  end

  // Read return is steered purely by the FIFO head, independent of the FSM
  always_comb begin
    p0_rdata_data  = m_rdata_data;
    p1_rdata_data  = m_rdata_data;
    p0_rdata_valid = m_rdata_valid & ~fifo_empty & ~head_id;
    p1_rdata_valid = m_rdata_valid & ~fifo_empty & head_id;
    m_rdata_ready  = ~fifo_empty & (head_id ? p1_rdata_ready : p0_rdata_ready);
  end

  // Read data with no outstanding tag is a protocol error; held until reset
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n)                      rd_err <= 1'b0;
    else if (m_rdata_valid & fifo_empty)  rd_err <= 1'b1;
  end

  litedram_tag_fifo #(
    .DEPTH (MAX_RD)
  ) u_tag_fifo (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .push       (tag_push),
    .push_id    (grant),
    .pop        (rd_pop),
    .head_id    (head_id),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .count      (rd_count)
  );

endmodule

// File: tb/tb_litedram_port_arbiter.sv
// Scoreboard bench for litedram_port_arbiter: requester drivers push expected
// commands/write beats, a DRAM model returns read data in order, and a monitor
// checks every handshake against the queued expectations.
`timescale 1ns/1ps
module tb_litedram_port_arbiter;
  import litedram_arb_pkg::*;

  typedef struct packed { logic we; logic [23:0] addr; } cmd_t;
  typedef struct packed { logic [31:0] be; logic [255:0] data; } wd_t;
  typedef struct packed { logic port; logic [255:0] data; } rd_t;
  typedef struct packed { logic [31:0] due; logic [255:0] data; } dr_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         p_cmd_valid [2];
  logic         p_cmd_ready [2];
  logic         p_cmd_we [2];
  logic [23:0]  p_cmd_addr [2];
  logic         p_wdata_valid [2];
  logic         p_wdata_ready [2];
  logic [31:0]  p_wdata_we [2];
  logic [255:0] p_wdata_data [2];
  logic         p_rdata_valid [2];
  logic         p_rdata_ready [2];
  logic [255:0] p_rdata_data [2];
  logic         m_cmd_valid, m_cmd_ready, m_cmd_we;
  logic [23:0]  m_cmd_addr;
  logic         m_wdata_valid, m_wdata_ready;
  logic [31:0]  m_wdata_we;
  logic [255:0] m_wdata_data;
  logic         m_rdata_valid, m_rdata_ready;
  logic [255:0] m_rdata_data;
  logic         busy, rd_err;

  litedram_port_arbiter dut (
    .user_clk(clk), .user_rst_n(rst_n),
    .p0_cmd_valid(p_cmd_valid[0]), .p0_cmd_ready(p_cmd_ready[0]), .p0_cmd_we(p_cmd_we[0]),
    .p0_cmd_addr(p_cmd_addr[0]), .p0_wdata_valid(p_wdata_valid[0]), .p0_wdata_ready(p_wdata_ready[0]),
    .p0_wdata_we(p_wdata_we[0]), .p0_wdata_data(p_wdata_data[0]), .p0_rdata_valid(p_rdata_valid[0]),
    .p0_rdata_ready(p_rdata_ready[0]), .p0_rdata_data(p_rdata_data[0]),
    .p1_cmd_valid(p_cmd_valid[1]), .p1_cmd_ready(p_cmd_ready[1]), .p1_cmd_we(p_cmd_we[1]),
    .p1_cmd_addr(p_cmd_addr[1]), .p1_wdata_valid(p_wdata_valid[1]), .p1_wdata_ready(p_wdata_ready[1]),
    .p1_wdata_we(p_wdata_we[1]), .p1_wdata_data(p_wdata_data[1]), .p1_rdata_valid(p_rdata_valid[1]),
    .p1_rdata_ready(p_rdata_ready[1]), .p1_rdata_data(p_rdata_data[1]),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_we(m_cmd_we), .m_cmd_addr(m_cmd_addr),
    .m_wdata_valid(m_wdata_valid), .m_wdata_ready(m_wdata_ready), .m_wdata_we(m_wdata_we),
    .m_wdata_data(m_wdata_data), .m_rdata_valid(m_rdata_valid), .m_rdata_ready(m_rdata_ready),
    .m_rdata_data(m_rdata_data), .busy(busy), .rd_err(rd_err)
  );

  cmd_t exp_cmd [2][$];
  wd_t  exp_wd [2][$];
  rd_t  rd_exp [$];
  dr_t  dram_q [$];
  int   exp_grant [$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] cyc = 0;
  bit rnd_ready = 0, ret_en = 1, fixed_data = 0, force_rv = 0, wready_hold = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: required event did not occur", nm);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // DRAM-side and requester-side drivers of the DUT's inputs that the bench does not own directly
  always @(posedge clk) begin
    #1;
    m_cmd_ready   = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    m_wdata_ready = wready_hold ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    for (int i = 0; i < 2; i++) p_rdata_ready[i] = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (force_rv) begin
      m_rdata_valid = 1'b1;
      m_rdata_data  = rnd256();
    end else if (ret_en && dram_q.size() > 0 && dram_q[0].due <= cyc) begin
      m_rdata_valid = 1'b1;
      m_rdata_data  = dram_q[0].data;
    end else begin
      m_rdata_valid = 1'b0;
    end
  end

  // Monitor: every handshake this cycle is compared against the scoreboards
  always @(negedge clk) begin
    int   hs_port, n_cmd_hs, n_wd_hs;
    cmd_t ec;
    wd_t  ew;
    rd_t  er;
    logic [255:0] d;
    if (rst_n) begin
      hs_port = -1; n_cmd_hs = 0; n_wd_hs = 0;
      for (int i = 0; i < 2; i++) begin
        if (p_cmd_valid[i] && p_cmd_ready[i]) begin
          hs_port = i; n_cmd_hs++;
          check("cmd_valid_at_hs", m_cmd_valid, 1);
          check("other_cmd_ready", p_cmd_ready[1-i], 0);
          if (exp_cmd[i].size() == 0) fail_evt("expected_cmd_queued");
          else begin
            ec = exp_cmd[i].pop_front();
            check("m_cmd_we", m_cmd_we, ec.we);
            check("m_cmd_addr", m_cmd_addr, ec.addr);
          end
          if (exp_grant.size() > 0) check("grant_order", i, exp_grant.pop_front());
        end
        if (p_wdata_valid[i] && p_wdata_ready[i]) begin
          n_wd_hs++;
          check("wdata_valid_at_hs", m_wdata_valid, 1);
          if (exp_wd[i].size() == 0) fail_evt("expected_wdata_queued");
          else begin
            ew = exp_wd[i].pop_front();
            check("m_wdata_data", m_wdata_data, ew.data);
            check("m_wdata_we", m_wdata_we, ew.be);
          end
        end
        if (p_rdata_valid[i] && p_rdata_ready[i]) begin
          check("other_rdata_valid", p_rdata_valid[1-i], 0);
          if (rd_exp.size() == 0) fail_evt("expected_rdata_queued");
          else begin
            er = rd_exp.pop_front();
            check("rdata_port", i, er.port);
            check("rdata_data", p_rdata_data[i], er.data);
          end
        end
      end
      if (m_cmd_valid && m_cmd_ready) begin
        check("cmd_hs_count", n_cmd_hs, 1);
        if (!m_cmd_we && hs_port >= 0) begin
          d = fixed_data ? {8{32'hAAAA_AAAA}} : rnd256();
          dram_q.push_back({cyc + 32'($urandom_range(2, 12)), d});
          rd_exp.push_back({hs_port[0], d});
        end
      end
      if (m_wdata_valid && m_wdata_ready) check("wdata_hs_count", n_wd_hs, 1);
      if (m_rdata_valid && m_rdata_ready && dram_q.size() > 0) void'(dram_q.pop_front());
    end
  end

  task automatic drive_port(input int i, input bit we, input logic [23:0] addr);
    wd_t w;
    bit ok;
    w.data = rnd256();
    w.be   = $urandom;
    exp_cmd[i].push_back({we, addr});
    if (we) exp_wd[i].push_back(w);
    p_cmd_we[i] = we; p_cmd_addr[i] = addr; p_cmd_valid[i] = 1'b1;
    if (we) begin
      p_wdata_valid[i] = 1'b1; p_wdata_data[i] = w.data; p_wdata_we[i] = w.be;
    end
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (p_cmd_ready[i]) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    p_cmd_valid[i] = 1'b0;
    if (!ok) fail_evt("cmd_grant_timeout");
    if (we) begin
      ok = 0;
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        if (p_wdata_ready[i]) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      p_wdata_valid[i] = 1'b0;
      if (!ok) fail_evt("wdata_accept_timeout");
    end
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (rd_exp.size() == 0 && dram_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    if (!ok) fail_evt("drain_timeout");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    // Reset with live-looking inputs: outputs must stay quiet
    rst_n = 1'b0;
    force_rv = 1;
    for (int i = 0; i < 2; i++) begin
      p_cmd_valid[i] = 1'b1; p_cmd_we[i] = 1'b1; p_cmd_addr[i] = 24'h5A5A5A;
      p_wdata_valid[i] = 1'b1; p_wdata_we[i] = '1; p_wdata_data[i] = rnd256();
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_cmd_valid", m_cmd_valid, 0);
    check("rst_m_cmd_addr", m_cmd_addr, 0);
    check("rst_m_cmd_we", m_cmd_we, 0);
    check("rst_m_wdata_valid", m_wdata_valid, 0);
    check("rst_m_wdata_data", m_wdata_data, 0);
    check("rst_m_rdata_ready", m_rdata_ready, 0);
    check("rst_p0_cmd_ready", p_cmd_ready[0], 0);
    check("rst_p1_wdata_ready", p_wdata_ready[1], 0);
    check("rst_p0_rdata_valid", p_rdata_valid[0], 0);
    check("rst_busy", busy, 0);
    check("rst_rd_err", rd_err, 0);
    force_rv = 0;
    for (int i = 0; i < 2; i++) begin
      p_cmd_valid[i] = 1'b0; p_wdata_valid[i] = 1'b0;
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // Both requesters contend with writes: alternating grants starting at p0
    exp_grant = '{0, 1, 0, 1};
    fork
      begin drive_port(0, 1, 24'h000100); drive_port(0, 1, 24'h000101); end
      begin drive_port(1, 1, 24'h000200); drive_port(1, 1, 24'h000201); end
    join
    check("grant_order_consumed", exp_grant.size(), 0);

    // Single p0 read at 0x000003: one-cycle command latency and routing
    @(posedge clk); #1;
    fixed_data = 1;
    exp_cmd[0].push_back({1'b0, 24'h000003});
    p_cmd_we[0] = 1'b0; p_cmd_addr[0] = 24'h000003; p_cmd_valid[0] = 1'b1;
    @(negedge clk);
    check("lat_cycle0_m_cmd_valid", m_cmd_valid, 0);
    @(negedge clk);
    check("lat_cycle1_m_cmd_valid", m_cmd_valid, 1);
    check("lat_m_cmd_we", m_cmd_we, 0);
    check("lat_m_cmd_addr", m_cmd_addr, 24'h000003);
    @(posedge clk); #1 p_cmd_valid[0] = 1'b0;
    @(negedge clk);
    check("one_cycle_m_cmd_valid", m_cmd_valid, 0);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (p_rdata_valid[0]) begin ok = 1; break; end
    end
    if (!ok) fail_evt("p0_rdata_timeout");
    else begin
      check("rd1_p1_rdata_valid", p_rdata_valid[1], 0);
      check("rd1_p0_rdata_data", p_rdata_data[0], {8{32'hAAAA_AAAA}});
    end
    fixed_data = 0;
    wait_drain();

    // Interleaved reads p1,p0,p1,p0 returned only after all are issued
    @(negedge clk) ret_en = 0;
    drive_port(1, 0, 24'h001000);
    drive_port(0, 0, 24'h001001);
    drive_port(1, 0, 24'h001002);
    drive_port(0, 0, 24'h001003);
    @(negedge clk);
    check("interleave_busy", busy, 1);
    check("interleave_pending", rd_exp.size(), 4);
    ret_en = 1;
    wait_drain();

    // Fill the tag FIFO; the 5th read waits while a write still gets through
    @(negedge clk) ret_en = 0;
    for (int k = 0; k < 4; k++) drive_port(0, 0, 24'($urandom));
    fork
      drive_port(0, 0, 24'h00ABCD);
      begin
        repeat (10) @(negedge clk);
        check("full_m_cmd_valid", m_cmd_valid, 0);
        check("full_busy", busy, 1);
        check("full_rd_count", dut.rd_count, 4);
        drive_port(1, 1, 24'h00BEEF);
        check("full_read_still_blocked", exp_cmd[0].size(), 1);
        @(negedge clk) ret_en = 1;
      end
    join
    wait_drain();

    // Randomized traffic with back-pressure on every handshake
    @(negedge clk) rnd_ready = 1;
    fork
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 drive_port(0, 1'($urandom_range(0, 1)), 24'($urandom));
      end
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 drive_port(1, 1'($urandom_range(0, 1)), 24'($urandom));
      end
    join
    @(negedge clk) rnd_ready = 0;
    wait_drain();

    // Read data with nothing outstanding: refused and flagged, sticky
    @(negedge clk) force_rv = 1;
    @(negedge clk);
    check("err_m_rdata_ready", m_rdata_ready, 0);
    check("err_p0_rdata_valid", p_rdata_valid[0], 0);
    check("err_p1_rdata_valid", p_rdata_valid[1], 0);
    force_rv = 0;
    @(posedge clk); #2;
    check("err_rd_err_set", rd_err, 1);
    repeat (5) @(negedge clk);
    check("err_rd_err_sticky", rd_err, 1);

    // Reset in WDATA with two reads outstanding
    ret_en = 0;
    drive_port(0, 0, 24'h002000);
    drive_port(0, 0, 24'h002001);
    @(negedge clk) wready_hold = 1;
    exp_cmd[1].push_back({1'b1, 24'h003000});
    p_cmd_we[1] = 1'b1; p_cmd_addr[1] = 24'h003000; p_cmd_valid[1] = 1'b1;
    p_wdata_valid[1] = 1'b1; p_wdata_data[1] = rnd256(); p_wdata_we[1] = '1;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (m_wdata_valid) begin ok = 1; break; end
    end
    if (!ok) fail_evt("reach_wdata_timeout");
    check("pre_rst_rd_count", dut.rd_count, 2);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_m_cmd_valid", m_cmd_valid, 0);
    check("mid_rst_m_wdata_valid", m_wdata_valid, 0);
    check("mid_rst_p1_wdata_ready", p_wdata_ready[1], 0);
    check("mid_rst_p1_cmd_ready", p_cmd_ready[1], 0);
    check("mid_rst_m_rdata_ready", m_rdata_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd_err", rd_err, 0);
    check("mid_rst_rd_count", dut.rd_count, 0);
    check("mid_rst_state", dut.state, IDLE);
    for (int i = 0; i < 2; i++) begin
      p_cmd_valid[i] = 1'b0; p_wdata_valid[i] = 1'b0;
    end
    dram_q.delete();
    rd_exp.delete();
    wready_hold = 0;
    ret_en = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Traffic resumes cleanly after reset
    drive_port(0, 0, 24'h004000);
    drive_port(1, 1, 24'h004001);
    wait_drain();
    check("end_rd_err", rd_err, 0);
    check("end_exp_cmd0", exp_cmd[0].size(), 0);
    check("end_exp_cmd1", exp_cmd[1].size(), 0);
    check("end_exp_wd0", exp_wd[0].size(), 0);
    check("end_exp_wd1", exp_wd[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
